simmem_linkedlist_bank_rr: RTL and testbench

Parametrised successor of the linked-list response bank. Stores messages tagged with an ID in one shared RAM. Each ID has its own linked-list FIFO; a free list tracks unused slots. IDs enabled by release_en_i are drained through one output port using locked round-robin arbitration. A per-ID occupancy cap prevents one ID from monopolising the RAM. Sits between the simulated-memory delay stage and the AXI response channel.

---
 rtl/simmem_linkedlist_bank_rr.sv | 157 +++++++++++++++
 tb/tb_simmem_linkedlist_bank_rr.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_linkedlist_bank_rr.sv
// Shared-RAM response bank: one linked-list FIFO per ID plus a bitmap free list,
// drained through a single port by locked round-robin arbitration with a per-ID cap.
module simmem_linkedlist_bank_rr #(
    parameter int StructWidth   = 10,
    parameter int TotalCapacity = 16,
    parameter int IdWidth       = 2,
    parameter int MaxPerId      = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [2**IdWidth-1:0]                  release_en_i,
    input  logic [StructWidth-1:0]                 data_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic [StructWidth-1:0]                 data_o,
    output logic [IdWidth-1:0]                     out_id_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [$clog2(TotalCapacity+1)-1:0]     free_cnt_o,
    output logic [2**IdWidth-1:0]                  nonempty_o
);

    localparam int NumIds = 2**IdWidth;
    localparam int SlotW  = $clog2(TotalCapacity);
    localparam int CntW   = $clog2(TotalCapacity+1);
    localparam int LenW   = $clog2(MaxPerId+1);

    typedef logic [SlotW-1:0]   slot_t;
    typedef logic [IdWidth-1:0] id_t;
    typedef logic [LenW-1:0]    len_t;

    logic [StructWidth-1:0] data_mem [TotalCapacity];
    slot_t                  next_mem [TotalCapacity];

    logic [TotalCapacity-1:0] free_map_q, free_map_nxt;
    logic [CntW-1:0]          free_cnt_q;
    slot_t                    head_q [NumIds];
    slot_t                    tail_q [NumIds];
    len_t                     len_q  [NumIds];
    slot_t                    head_nxt [NumIds];
    slot_t                    tail_nxt [NumIds];
    len_t                     len_nxt  [NumIds];
    logic                     locked_q;
    id_t                      lock_id_q;
    id_t                      rr_q;

    id_t                      in_id;
    slot_t                    alloc_slot;
    logic                     push;
    logic                     pop;
    logic                     link_tail;
    len_t                     in_len_ap;
    logic [NumIds-1:0]        eligible;
    id_t                      arb_id;
    logic                     arb_found;
    id_t                      gnt_id;
    slot_t                    pop_slot;

    assign in_id      = data_i[IdWidth-1:0];
    assign in_ready_o = (free_cnt_q != '0) && (len_q[in_id] < len_t'(MaxPerId));
    assign push       = in_valid_i && in_ready_o;

    // Lowest-numbered free slot wins, so allocation order is deterministic.
    always_comb begin
        alloc_slot = '0;
        for (int s = TotalCapacity-1; s >= 0; s--) begin
            if (free_map_q[s]) alloc_slot = slot_t'(s);
        end
    end

    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            eligible[i]   = (len_q[i] != '0) && release_en_i[i];
            nonempty_o[i] = (len_q[i] != '0);
        end
    end

    // Search starts one past the last granted ID; k == NumIds wraps back onto rr_q.
    always_comb begin
        arb_id    = rr_q;
        arb_found = 1'b0;
        for (int k = 1; k <= NumIds; k++) begin
            if (!arb_found && eligible[rr_q + id_t'(k)]) begin
                arb_found = 1'b1;
                arb_id    = rr_q + id_t'(k);
            end
        end
    end

    assign gnt_id      = locked_q ? lock_id_q : arb_id;
    assign out_valid_o = locked_q || arb_found;
    assign pop         = out_valid_o && out_ready_i;
    assign pop_slot    = head_q[gnt_id];
    assign data_o      = data_mem[pop_slot];
    assign out_id_o    = gnt_id;
    assign free_cnt_o  = free_cnt_q;

    always_comb begin
        free_map_nxt = free_map_q;
        if (push) free_map_nxt[alloc_slot] = 1'b0;
        if (pop)  free_map_nxt[pop_slot]   = 1'b1;
    end

    // Pop is applied first so a same-ID push onto a draining single-entry list
    // sees it as empty and takes over the head.
    always_comb begin
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        len_nxt   = len_q;
        link_tail = 1'b0;
        if (pop) begin
            head_nxt[gnt_id] = next_mem[pop_slot];
            len_nxt[gnt_id]  = len_q[gnt_id] - len_t'(1);
        end
        in_len_ap = len_nxt[in_id];
        if (push) begin
            if (in_len_ap == '0) head_nxt[in_id] = alloc_slot;
            else                 link_tail       = 1'b1;
            tail_nxt[in_id] = alloc_slot;
            len_nxt[in_id]  = in_len_ap + len_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_map_q <= '1;
            free_cnt_q <= CntW'(TotalCapacity);
            for (int i = 0; i < NumIds; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                len_q[i]  <= '0;
            end
            locked_q  <= 1'b0;
            lock_id_q <= '0;
            rr_q      <= id_t'(NumIds-1);
        end else begin
            free_map_q <= free_map_nxt;
            free_cnt_q <= free_cnt_q - CntW'(push) + CntW'(pop);
            head_q     <= head_nxt;
            tail_q     <= tail_nxt;
            len_q      <= len_nxt;
            locked_q   <= out_valid_o && !out_ready_i;
            lock_id_q  <= gnt_id;
            if (pop) rr_q <= gnt_id;
        end
    end

    // Payload storage carries no reset; only list bookkeeping decides validity.
    always_ff @(posedge clk_i) begin
        if (push)      data_mem[alloc_slot]     <= data_i;
        if (link_tail) next_mem[tail_q[in_id]] <= alloc_slot;
    end

    a_out_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(out_valid_o));

endmodule

// File: tb/tb_simmem_linkedlist_bank_rr.sv
// Directed and scoreboard-checked bench for the linked-list response bank (MaxPerId=4).
module tb_simmem_linkedlist_bank_rr;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] release_en_i;
    logic [9:0] data_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [9:0] data_o;
    logic [1:0] out_id_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [4:0] free_cnt_o;
    logic [3:0] nonempty_o;

    int checks   = 0;
    int failures = 0;

    simmem_linkedlist_bank_rr #(
        .StructWidth(10), .TotalCapacity(16), .IdWidth(2), .MaxPerId(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .release_en_i(release_en_i),
        .data_i(data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_o(data_o), .out_id_o(out_id_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .free_cnt_o(free_cnt_o), .nonempty_o(nonempty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b0;
        release_en_i = 4'b0000;
        data_i       = '0;
        rst_ni       = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic push_one(input logic [9:0] d);
        data_i     = d;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    logic [9:0] sbq [4][$];

    function automatic int sb_total();
        int t = 0;
        for (int i = 0; i < 4; i++) t += sbq[i].size();
        return t;
    endfunction

    initial begin
        logic [9:0] exp_a [6];
        logic [9:0] d;
        logic [9:0] front;
        int accepted;
        int cycles;
        int tot;
        logic exp_rdy;

        rst_ni = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        release_en_i = 4'b0000; data_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_free_cnt", free_cnt_o, 16);
        check("rst_nonempty", nonempty_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        tick(); tick();
        rst_ni = 1'b1;

        // Single-ID ordering and one-cycle latency
        release_en_i = 4'b0001;
        data_i = 10'h004; in_valid_i = 1'b1;
        settle();
        check("t1_pre_valid", out_valid_o, 0);
        check("t1_in_ready", in_ready_o, 1);
        tick(); settle();
        check("t1_lat_valid", out_valid_o, 1);
        check("t1_lat_data", data_o, 10'h004);
        data_i = 10'h008; tick();
        data_i = 10'h00C; tick();
        in_valid_i = 1'b0; settle();
        check("t1_free_cnt", free_cnt_o, 13);
        exp_a[0] = 10'h004; exp_a[1] = 10'h008; exp_a[2] = 10'h00C;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t1_order_data", data_o, exp_a[i]);
            tick();
        end
        settle();
        check("t1_drained_valid", out_valid_o, 0);
        check("t1_drained_free", free_cnt_o, 16);

        // Round-robin across all IDs, then alternation between two
        do_reset();
        for (int i = 0; i < 4; i++) push_one(10'h010 | 10'(i));
        release_en_i = 4'b1111; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t2_rr_id", out_id_o, i);
            check("t2_rr_data", data_o, 10'h010 | 10'(i));
            tick();
        end
        out_ready_i = 1'b0; release_en_i = 4'b0000;
        exp_a[0] = 10'h021; exp_a[1] = 10'h022; exp_a[2] = 10'h025;
        exp_a[3] = 10'h026; exp_a[4] = 10'h029; exp_a[5] = 10'h02A;
        for (int i = 0; i < 6; i++) push_one(exp_a[i]);
        release_en_i = 4'b0110; out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("t2_alt_id", out_id_o, (i % 2 == 0) ? 1 : 2);
            check("t2_alt_data", data_o, exp_a[i]);
            tick();
        end
        out_ready_i = 1'b0;

        // Lock holds the grant while release and competing traffic change
        do_reset();
        release_en_i = 4'b0100;
        push_one(10'h032);
        settle();
        check("t3_valid", out_valid_o, 1);
        check("t3_first_id", out_id_o, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            release_en_i = (i % 2 == 0) ? 4'b0001 : 4'b0101;
            in_valid_i = (i == 0);
            data_i = 10'h030;
            settle();
            check("t3_lock_id", out_id_o, 2);
            check("t3_lock_data", data_o, 10'h032);
            tick();
        end
        in_valid_i = 1'b0; release_en_i = 4'b0001; out_ready_i = 1'b1;
        settle();
        check("t3_hs_valid", out_valid_o, 1);
        check("t3_hs_id", out_id_o, 2);
        check("t3_hs_data", data_o, 10'h032);
        tick(); settle();
        check("t3_next_id", out_id_o, 0);
        check("t3_next_data", data_o, 10'h030);
        tick(); settle();
        check("t3_empty_valid", out_valid_o, 0);
        out_ready_i = 1'b0;

        // Full RAM, then simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            data_i = 10'((i << 4) | (i & 3)); in_valid_i = 1'b1;
            settle();
            check("t4_fill_ready", in_ready_o, 1);
            tick();
        end
        in_valid_i = 1'b0; data_i = 10'h001; settle();
        check("t4_full_free", free_cnt_o, 0);
        check("t4_full_ready", in_ready_o, 0);
        check("t4_full_nonempty", nonempty_o, 4'b1111);
        release_en_i = 4'b0001; out_ready_i = 1'b1;
        settle();
        check("t4_pop1_data", data_o, 10'h000);
        tick();
        data_i = 10'h104; in_valid_i = 1'b1; settle();
        check("t4_pp_ready", in_ready_o, 1);
        check("t4_pp_data", data_o, 10'h040);
        tick();
        in_valid_i = 1'b0; out_ready_i = 1'b0; settle();
        check("t4_pp_free", free_cnt_o, 1);
        data_i = 10'h3F1; settle();
        check("t4_cap_id1_ready", in_ready_o, 0);
        data_i = 10'h108; in_valid_i = 1'b1; settle();
        check("t4_id0_ready", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0; data_i = 10'h10C; settle();
        check("t4_refull_ready", in_ready_o, 0);
        check("t4_refull_free", free_cnt_o, 0);
        exp_a[0] = 10'h080; exp_a[1] = 10'h0C0; exp_a[2] = 10'h104; exp_a[3] = 10'h108;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t4_drain_data", data_o, exp_a[i]);
            tick();
        end
        settle();
        check("t4_drain_valid", out_valid_o, 0);
        check("t4_drain_nonempty", nonempty_o, 4'b1110);
        out_ready_i = 1'b0;

        // Per-ID cap only blocks the capped ID
        do_reset();
        push_one(10'h003); push_one(10'h007); push_one(10'h00B); push_one(10'h00F);
        data_i = 10'h013; settle();
        check("t5_cap_id3", in_ready_o, 0);
        data_i = 10'h011; settle();
        check("t5_cap_id1", in_ready_o, 1);
        release_en_i = 4'b1000; out_ready_i = 1'b1; settle();
        check("t5_pop_data", data_o, 10'h003);
        tick();
        out_ready_i = 1'b0; release_en_i = 4'b0000;
        data_i = 10'h013; in_valid_i = 1'b1; settle();
        check("t5_reaccept", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0; settle();
        check("t5_free", free_cnt_o, 12);
        check("t5_nonempty", nonempty_o, 4'b1000);

        // Asynchronous reset mid-stream
        do_reset();
        release_en_i = 4'b1111;
        for (int i = 0; i < 7; i++) push_one(10'h100 | 10'(i));
        settle();
        check("t6_pre_free", free_cnt_o, 9);
        rst_ni = 1'b0; #1;
        check("t6_rst_valid", out_valid_o, 0);
        check("t6_rst_free", free_cnt_o, 16);
        check("t6_rst_nonempty", nonempty_o, 0);
        tick();
        rst_ni = 1'b1;

        // Random valid/ready traffic against per-ID scoreboards
        accepted = 0;
        cycles   = 0;
        while ((accepted < 1000 || sb_total() > 0) && cycles < 30000) begin
            if (accepted < 1000) begin
                in_valid_i   = ($urandom_range(0, 2) != 0);
                data_i       = 10'($urandom);
                release_en_i = 4'($urandom);
                out_ready_i  = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid_i   = 1'b0;
                release_en_i = 4'b1111;
                out_ready_i  = 1'b1;
            end
            settle();
            tot = sb_total();
            exp_rdy = (tot < 16) && (sbq[data_i[1:0]].size() < 4);
            check("rnd_in_ready", in_ready_o, exp_rdy);
            check("rnd_free_cnt", free_cnt_o, 16 - tot);
            if (out_valid_o && out_ready_i) begin
                check("rnd_id_field", data_o[1:0], out_id_o);
                if (sbq[out_id_o].size() == 0) begin
                    check("rnd_pop_nonempty", 0, 1);
                end else begin
                    front = sbq[out_id_o].pop_front();
                    check("rnd_data", data_o, front);
                end
            end
            if (in_valid_i && in_ready_o) begin
                d = data_i;
                sbq[d[1:0]].push_back(d);
                accepted++;
            end
            tick();
            cycles++;
        end
        check("rnd_all_accepted", accepted, 1000);
        check("rnd_all_drained", sb_total(), 0);
        settle();
        check("rnd_final_free", free_cnt_o, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
